// File: rtl/spi_slave_reg_if.sv
// spi_slave_reg_if: SPI command decoder and register bank behind a byte-level SPI slave shifter
//   clk, rst              system clock; synchronous active-high reset
//   ssn                   slave select, active low (same net as the shifter)
//   rx_done, rx_data      byte-complete flag and received byte from the shifter
//   tx_data               byte the shifter sends on the next transfer
//   wr_strobe/addr/data   one-cycle notification of each accepted SPI write
//   host_addr, host_rdata combinational local read port
//   busy                  high while a frame is in progress
// Optional: define SPI_REG_IF_RO_ID_EN to make register 0 a read-only ID_VALUE.
module spi_slave_reg_if #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W = 4,
    parameter logic [7:0] ID_VALUE = 8'h5A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ssn,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    output logic [7:0]        tx_data,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [7:0]        host_rdata,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, CMD, WR, RD} state_t;
`ifdef SPI_REG_IF_RO_ID_EN
    localparam bit RO_ID = 1'b1;
`else
    localparam bit RO_ID = 1'b0;
`endif
    localparam logic [7:0] NUM_LIM = 8'(NUM_REGS);
    localparam logic [6:0] PTR_MASK = 7'(NUM_REGS - 1);
    state_t state, state_n;
    logic [7:0] regs [NUM_REGS];
    logic rx_done_q, byte_ev, in_range, wr_ok;
    logic [6:0] ptr, ptr_p1, ptr_inc;
    function automatic logic [7:0] reg_rd(input logic [ADDR_W-1:0] a);
        return (RO_ID && a == '0) ? ID_VALUE : regs[a];
    endfunction
    function automatic logic [7:0] spi_rd(input logic [6:0] a);
        return ({1'b0, a} < NUM_LIM) ? reg_rd(a[ADDR_W-1:0]) : 8'h00;
    endfunction
    assign byte_ev = rx_done & ~rx_done_q;
    assign in_range = {1'b0, ptr} < NUM_LIM;
    assign wr_ok = in_range && !(RO_ID && ptr == 7'd0);
    assign ptr_p1 = ptr + 7'd1;
    // in-range pointers wrap inside the bank; out-of-range ones use plain 7-bit wrap
    assign ptr_inc = in_range ? (ptr_p1 & PTR_MASK) : ptr_p1;
    assign host_rdata = reg_rd(host_addr);
    always_comb begin
        state_n = state;
        if (state == IDLE) state_n = ssn ? IDLE : CMD;
        else if (ssn) state_n = IDLE;
        else if (state == CMD && byte_ev) state_n = rx_data[7] ? RD : WR;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rx_done_q <= 1'b0;
            ptr <= 7'd0;
            tx_data <= 8'h00;
            wr_strobe <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
            busy <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            state <= state_n;
            rx_done_q <= rx_done;
            busy <= state_n != IDLE;
            wr_strobe <= 1'b0;
            if (byte_ev) begin
                case (state)
                    CMD: begin
                        ptr <= rx_data[6:0];
                        if (rx_data[7]) tx_data <= spi_rd(rx_data[6:0]);
                    end
                    WR: begin
                        if (wr_ok) begin
                            regs[ptr[ADDR_W-1:0]] <= rx_data;
                            wr_strobe <= 1'b1;
                            wr_addr <= ptr[ADDR_W-1:0];
                            wr_data <= rx_data;
                        end
                        ptr <= ptr_inc;
                    end
                    RD: begin
                        ptr <= ptr_inc;
                        tx_data <= spi_rd(ptr_inc);
                    end
                    default: ;
                endcase
            end
            // a byte arriving as ssn rises is still handled, but the frame ends with tx cleared
            if (state != IDLE && ssn) tx_data <= 8'h00;
        end
    end
endmodule
